pipe_stage_skid_reg: RTL



---
 rtl/pipe_stage_pkg.sv | 12 +
 rtl/pipe_entry_reg.sv | 38 +++
 rtl/pipe_stage_skid_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared state encoding and default bubble control value for the pipeline stage register.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam int unsigned CTRL_BUBBLE_DEFAULT = 1;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline payload entry with load enable and synchronous clear-to-bubble.
module pipe_entry_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 2,
  parameter int unsigned       DST_W       = 5,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data_d,
  input  logic [DATA_W-1:0] alu_d,
  input  logic [CTRL_W-1:0] control_d,
  input  logic [DST_W-1:0]  regdst_d,
  output logic [DATA_W-1:0] data_q,
  output logic [DATA_W-1:0] alu_q,
  output logic [CTRL_W-1:0] control_q,
  output logic [DST_W-1:0]  regdst_q
);

  // Clear wins over load so a flush in the same cycle discards the incoming entry.
  always_ff @(posedge clk) begin
    if (clear) begin
      data_q    <= '0;
      alu_q     <= '0;
      control_q <= CTRL_BUBBLE;
      regdst_q  <= '0;
    end else if (load) begin
      data_q    <= data_d;
      alu_q     <= alu_d;
      control_q <= control_d;
      regdst_q  <= regdst_d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Optional stall counter output enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 2,
  parameter int unsigned       DST_W       = 5,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT),
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DST_W-1:0]  regdst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [DST_W-1:0]  regdst_out
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  state_e state_q, state_d;

  logic acc, drn, kill;
  logic out_load, out_from_skid, out_bubble, skid_load;

  logic [DATA_W-1:0] skid_data, skid_alu;
  logic [CTRL_W-1:0] skid_control;
  logic [DST_W-1:0]  skid_regdst;

  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign kill      = ~reset | mem_flush;
  assign out_valid = (state_q != ST_EMPTY);

  always_comb begin
    state_d       = state_q;
    out_load      = 1'b0;
    out_from_skid = 1'b0;
    out_bubble    = 1'b0;
    skid_load     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          out_load = 1'b1;
          state_d  = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (acc && drn) begin
          out_load = 1'b1;
        end else if (acc) begin
          skid_load = 1'b1;
          state_d   = ST_SKID;
        end else if (drn) begin
          out_bubble = 1'b1;
          state_d    = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (drn) begin
          out_load      = 1'b1;
          out_from_skid = 1'b1;
          state_d       = ST_MAIN;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // in_ready is registered from the next state so upstream sees a flop output.
  always_ff @(posedge clk) begin
    if (kill) begin
      state_q  <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != ST_SKID);
    end
  end

  pipe_entry_reg #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .DST_W       (DST_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_out_entry (
    .clk       (clk),
    .clear     (kill | out_bubble),
    .load      (out_load),
    .data_d    (out_from_skid ? skid_data    : data_in),
    .alu_d     (out_from_skid ? skid_alu     : alu_in),
    .control_d (out_from_skid ? skid_control : control_in),
    .regdst_d  (out_from_skid ? skid_regdst  : regdst_in),
    .data_q    (data_out),
    .alu_q     (alu_out),
    .control_q (control_out),
    .regdst_q  (regdst_out)
  );

  pipe_entry_reg #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .DST_W       (DST_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_skid_entry (
    .clk       (clk),
    .clear     (kill),
    .load      (skid_load),
    .data_d    (data_in),
    .alu_d     (alu_in),
    .control_d (control_in),
    .regdst_d  (regdst_in),
    .data_q    (skid_data),
    .alu_q     (skid_alu),
    .control_q (skid_control),
    .regdst_q  (skid_regdst)
  );

`ifdef PIPE_STAGE_PERF_EN
  // Saturating count of cycles the downstream stage back-pressures a valid entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
`endif

endmodule
